// File: rtl/mips_writeback_stage.sv
// MIPS writeback stage: retires ALU results and variable-latency loads into the
// register-file write port, with lane extraction, flush/drop handling and a load timeout.
module mips_writeback_stage #(
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wr,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_result,
  input  logic        in_is_load,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [1:0]  in_addr_lo,
  input  logic        flush,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wr_en,
  output logic [4:0]  wr_num,
  output logic [31:0] wr_data,
  output logic        pend_valid,
  output logic [4:0]  pend_num,
  output logic        err
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_WAIT    = 2'd1;
  localparam logic [1:0]  ST_DROP    = 2'd2;
  localparam bit          TMO_EN     = (TIMEOUT > 0);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

  logic [1:0]  state_r, state_nx_s;
  logic [15:0] cnt_r, cnt_nx_s;
  logic [4:0]  dest_r;
  logic        wr_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic [1:0]  addr_lo_r;
  logic        wr_en_r, err_r;
  logic [4:0]  wr_num_r;
  logic [31:0] wr_data_r;

  logic        accept_s, latch_s, done_s, alu_s, tmo_s, tmo_hit_s, sel_wait_s, bad_s;
  logic [4:0]  c_dest_s;
  logic        c_wr_s, c_signed_s;
  logic [1:0]  c_size_s, c_lo_s;
  logic [31:0] ld_data_s;

  // Big-endian flips both the byte lane (3-lo) and the halfword lane.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] lo);
    logic [1:0]  lane;
    logic        hlane;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    lane  = (BIG_ENDIAN != 0) ? ~lo : lo;
    hlane = (BIG_ENDIAN != 0) ? ~lo[1] : lo[1];
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = 8'h00;
    endcase
    h = hlane ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  function automatic logic load_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign accept_s   = in_valid & (state_r == ST_IDLE) & ~flush;
  assign tmo_hit_s  = TMO_EN & (cnt_r == TMO_LAST);
  assign sel_wait_s = (state_r == ST_WAIT);

  // A completing load uses the latched fields in WAIT_MEM, the live inputs otherwise.
  assign c_dest_s   = sel_wait_s ? dest_r    : in_dest;
  assign c_wr_s     = sel_wait_s ? wr_r      : in_wr;
  assign c_size_s   = sel_wait_s ? size_r    : in_size;
  assign c_signed_s = sel_wait_s ? signed_r  : in_signed;
  assign c_lo_s     = sel_wait_s ? addr_lo_r : in_addr_lo;
  assign bad_s      = load_bad(c_size_s, c_lo_s);
  assign ld_data_s  = load_extract(mem_rdata, c_size_s, c_signed_s, c_lo_s);

  // Next-state, counter and event decode.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    latch_s    = 1'b0;
    done_s     = 1'b0;
    alu_s      = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (!in_is_load) begin
            alu_s = 1'b1;
          end else if (mem_rvalid) begin
            done_s = 1'b1;
          end else begin
            latch_s    = 1'b1;
            state_nx_s = ST_WAIT;
            cnt_nx_s   = 16'd0;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          done_s     = ~flush;
          state_nx_s = ST_IDLE;
        end else if (flush) begin
          state_nx_s = ST_DROP;
        end else if (tmo_hit_s) begin
          state_nx_s = ST_DROP;
          tmo_s      = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + 16'd1;
        end
      end
      ST_DROP: begin
        if (mem_rvalid) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DROP;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Control state and latched load fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      dest_r    <= 5'd0;
      wr_r      <= 1'b0;
      size_r    <= 2'd0;
      signed_r  <= 1'b0;
      addr_lo_r <= 2'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if (latch_s) begin
        dest_r    <= in_dest;
        wr_r      <= in_wr;
        size_r    <= in_size;
        signed_r  <= in_signed;
        addr_lo_r <= in_addr_lo;
      end
    end
  end

  // Registered register-file write port and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_r   <= 1'b0;
      wr_num_r  <= 5'd0;
      wr_data_r <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      err_r <= tmo_s | (done_s & bad_s);
      if (alu_s) begin
        wr_en_r   <= in_wr & (in_dest != 5'd0);
        wr_num_r  <= in_dest;
        wr_data_r <= in_result;
      end else if (done_s) begin
        wr_en_r   <= c_wr_s & (c_dest_s != 5'd0) & ~bad_s;
        wr_num_r  <= c_dest_s;
        wr_data_r <= ld_data_s;
      end else begin
        wr_en_r <= 1'b0;
      end
    end
  end

  assign in_ready   = (state_r == ST_IDLE);
  assign pend_valid = sel_wait_s;
  assign pend_num   = sel_wait_s ? dest_r : 5'd0;
  assign wr_en      = wr_en_r;
  assign wr_num     = wr_num_r;
  assign wr_data    = wr_data_r;
  assign err        = err_r;

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Bench for mips_writeback_stage: a little-endian/TIMEOUT=4 and a big-endian/no-timeout
// instance share stimulus and are compared each cycle against a transaction-level model.
module tb_mips_writeback_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_wr = 1'b0, in_is_load = 1'b0, in_signed = 1'b0;
  logic        flush = 1'b0, mem_rvalid = 1'b0;
  logic [4:0]  in_dest = 5'd0;
  logic [31:0] in_result = 32'd0, mem_rdata = 32'd0;
  logic [1:0]  in_size = 2'd0, in_addr_lo = 2'd0;

  logic        rdy_le, we_le, pv_le, er_le, rdy_be, we_be, pv_be, er_be;
  logic [4:0]  wn_le, pn_le, wn_be, pn_be;
  logic [31:0] wd_le, wd_be;

  int checks = 0;
  int errors = 0;

  // Model: 0 = no load outstanding, 1 = awaiting data, 2 = discarding next data beat.
  int          mode   [2];
  int          waited [2];
  int          tmo    [2] = '{4, 0};
  int          big    [2] = '{0, 1};
  logic [4:0]  l_dest [2];
  logic        l_wr   [2];
  logic [1:0]  l_size [2];
  logic        l_sgn  [2];
  logic [1:0]  l_lo   [2];
  logic        e_we   [2];
  logic [4:0]  e_num  [2];
  logic [31:0] e_data [2];
  logic        e_err  [2];

  always #5 clk = ~clk;

  mips_writeback_stage #(.BIG_ENDIAN(0), .TIMEOUT(4)) dut_le (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_le), .in_wr(in_wr),
    .in_dest(in_dest), .in_result(in_result), .in_is_load(in_is_load), .in_size(in_size),
    .in_signed(in_signed), .in_addr_lo(in_addr_lo), .flush(flush), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wr_en(we_le), .wr_num(wn_le), .wr_data(wd_le),
    .pend_valid(pv_le), .pend_num(pn_le), .err(er_le));

  mips_writeback_stage #(.BIG_ENDIAN(1), .TIMEOUT(0)) dut_be (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_be), .in_wr(in_wr),
    .in_dest(in_dest), .in_result(in_result), .in_is_load(in_is_load), .in_size(in_size),
    .in_signed(in_signed), .in_addr_lo(in_addr_lo), .flush(flush), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wr_en(we_be), .wr_num(wn_be), .wr_data(wd_be),
    .pend_valid(pv_be), .pend_num(pn_be), .err(er_be));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input int be, input logic [1:0] size, input logic sgn,
                                           input logic [1:0] lo, input logic [31:0] w);
    int sh;
    logic [31:0] v;
    if (size == 2'd0) begin
      sh = (be != 0) ? 8 * (3 - int'(lo)) : 8 * int'(lo);
      v  = (w >> sh) & 32'h0000_00FF;
      if (sgn && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (((be != 0) ? (lo < 2'd2) : (lo >= 2'd2))) ? (w >> 16) : (w & 32'h0000_FFFF);
      if (sgn && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic model_complete(input int k, input logic wr, input logic [4:0] dest,
                                input logic [1:0] size, input logic sgn, input logic [1:0] lo);
    logic bad;
    bad = (size == 2'd3) || (size == 2'd1 && lo[0]) || (size == 2'd2 && lo != 2'd0);
    if (bad) begin
      e_err[k] = 1'b1;
    end else begin
      e_we[k]   = wr && (dest != 5'd0);
      e_num[k]  = dest;
      e_data[k] = ref_load(big[k], size, sgn, lo, mem_rdata);
    end
  endtask

  task automatic model_step(input int k);
    e_we[k]  = 1'b0;
    e_err[k] = 1'b0;
    if (mode[k] == 0) begin
      if (in_valid && !flush) begin
        if (!in_is_load) begin
          e_we[k]   = in_wr && (in_dest != 5'd0);
          e_num[k]  = in_dest;
          e_data[k] = in_result;
        end else if (mem_rvalid) begin
          model_complete(k, in_wr, in_dest, in_size, in_signed, in_addr_lo);
        end else begin
          mode[k] = 1; waited[k] = 0;
          l_dest[k] = in_dest; l_wr[k] = in_wr; l_size[k] = in_size;
          l_sgn[k] = in_signed; l_lo[k] = in_addr_lo;
        end
      end
    end else if (mode[k] == 1) begin
      if (mem_rvalid) begin
        if (!flush) model_complete(k, l_wr[k], l_dest[k], l_size[k], l_sgn[k], l_lo[k]);
        mode[k] = 0;
      end else if (flush) begin
        mode[k] = 2;
      end else begin
        waited[k]++;
        if (tmo[k] > 0 && waited[k] == tmo[k]) begin
          mode[k] = 2; e_err[k] = 1'b1;
        end
      end
    end else if (mem_rvalid) begin
      mode[k] = 0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; waited[k] = 0; l_dest[k] = 5'd0; l_wr[k] = 1'b0; l_size[k] = 2'd0;
      l_sgn[k] = 1'b0; l_lo[k] = 2'd0; e_we[k] = 1'b0; e_num[k] = 5'd0;
      e_data[k] = 32'd0; e_err[k] = 1'b0;
    end
  endtask

  task automatic compare_one(input int k, input logic rdy, input logic we, input logic [4:0] wn,
                             input logic [31:0] wd, input logic pv, input logic [4:0] pn,
                             input logic er);
    string p;
    p = (k == 0) ? "le" : "be";
    check_val({p, ".in_ready"}, 32'(rdy), 32'(mode[k] == 0));
    check_val({p, ".pend_valid"}, 32'(pv), 32'(mode[k] == 1));
    check_val({p, ".pend_num"}, 32'(pn), (mode[k] == 1) ? 32'(l_dest[k]) : 32'd0);
    check_val({p, ".wr_en"}, 32'(we), 32'(e_we[k]));
    check_val({p, ".err"}, 32'(er), 32'(e_err[k]));
    if (e_we[k]) begin
      check_val({p, ".wr_num"}, 32'(wn), 32'(e_num[k]));
      check_val({p, ".wr_data"}, wd, e_data[k]);
    end
  endtask

  task automatic compare_all();
    compare_one(0, rdy_le, we_le, wn_le, wd_le, pv_le, pn_le, er_le);
    compare_one(1, rdy_be, we_be, wn_be, wd_be, pv_be, pn_be, er_be);
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, check at the next falling edge.
  task automatic cyc(input logic v, input logic wr, input logic [4:0] dest, input logic [31:0] res,
                     input logic ld, input logic [1:0] size, input logic sgn, input logic [1:0] lo,
                     input logic fl, input logic rv, input logic [31:0] rd);
    in_valid = v; in_wr = wr; in_dest = dest; in_result = res; in_is_load = ld; in_size = size;
    in_signed = sgn; in_addr_lo = lo; flush = fl; mem_rvalid = rv; mem_rdata = rd;
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic rvalid_only(input logic [31:0] rd);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, rd);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    logic prev_rv;
    logic rv;
    #2;
    apply_reset();

    // ALU write, then the write port drops again.
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    check_val("t1.wr_data", wd_le, 32'hDEADBEEF);
    idle(1);

    // LB signed at addr 3, data three cycles later.
    cyc(1'b1, 1'b1, 5'd9, 32'd0, 1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 32'd0);
    idle(2);
    rvalid_only(32'h80FF1234);
    check_val("t2.wr_data", wd_le, 32'hFFFFFF80);

    // LHU same-cycle data, then a misaligned LH.
    cyc(1'b1, 1'b1, 5'd3, 32'd0, 1'b1, 2'd1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h80FF1234);
    check_val("t3.le", wd_le, 32'h000080FF);
    check_val("t3.be", wd_be, 32'h00001234);
    cyc(1'b1, 1'b1, 5'd4, 32'd0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 1'b1, 32'h80FF1234);
    check_val("t3.err", 32'(er_le), 32'd1);

    // No write for dest 0 or in_wr=0; LW with same-cycle data.
    cyc(1'b1, 1'b1, 5'd0, 32'h1111_1111, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 5'd7, 32'h2222_2222, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 5'd8, 32'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b1, 32'hCAFE_F00D);

    // Flush while waiting, data arrives later and is dropped; stray rvalid in IDLE.
    cyc(1'b1, 1'b1, 5'd10, 32'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0);
    idle(1);
    rvalid_only(32'h1234_5678);
    rvalid_only(32'h9ABC_DEF0);

    // Timeout on the LE instance, then reset while a load is pending.
    cyc(1'b1, 1'b1, 5'd12, 32'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0);
    idle(6);
    rvalid_only(32'h0BAD_F00D);
    cyc(1'b1, 1'b1, 5'd13, 32'd0, 1'b1, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0, 32'd0);
    idle(1);
    apply_reset();

    prev_rv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
        prev_rv = 1'b0;
      end else begin
        rv = !prev_rv && ($urandom_range(0, 3) == 0);
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, 5'($urandom_range(0, 31)),
            $urandom, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 15) == 0, rv, $urandom);
        prev_rv = rv;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
